// File: rtl/keccak_padder.sv
// rtl/keccak_padder.sv - packs 32-bit host words into 576-bit blocks with pad10*1 padding
module keccak_padder #(
  parameter int RATE_WORDS = 18
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [31:0]               in,
  input  logic                      in_ready,
  input  logic                      is_last,
  input  logic [1:0]                byte_num,
  output logic                      buffer_full,
  output logic [32*RATE_WORDS-1:0]  out,
  output logic                      out_ready,
  input  logic                      f_ack
);

  localparam int BLOCK_W = 32 * RATE_WORDS;
  localparam logic [4:0] FULL_COUNT = 5'(RATE_WORDS);
  localparam logic [4:0] LAST_SLOT  = 5'(RATE_WORDS - 1);

  typedef enum logic [1:0] {
    ACCEPT,
    PAD,
    DONE
  } state_t;

  state_t      state, state_nx;
  logic [4:0]  count;
  logic        push;
  logic [31:0] push_word;
  logic [31:0] last_word;

  assign buffer_full = (count == FULL_COUNT);
  assign out_ready   = buffer_full;

  // Final message word: keep the valid leading bytes, drop in the 0x01 pad byte right after them.
  always_comb begin
    last_word = 32'h0100_0000;
    case (byte_num)
      2'd0: last_word = 32'h0100_0000;
      2'd1: last_word = {in[31:24], 24'h01_0000};
      2'd2: last_word = {in[31:16], 16'h0100};
      2'd3: last_word = {in[31:8], 8'h01};
      default: last_word = 32'h0100_0000;
    endcase
  end

  // Next state and the word to shift in; nothing is pushed while a full block awaits its ack.
  always_comb begin
    state_nx  = state;
    push      = 1'b0;
    push_word = 32'h0;
    case (state)
      ACCEPT: begin
        if (in_ready && !buffer_full) begin
          push = 1'b1;
          if (is_last) begin
            if (count == LAST_SLOT) begin
              // The final pad bit shares the last block byte with the message tail.
              push_word = last_word | 32'h0000_0080;
              state_nx  = DONE;
            end else begin
              push_word = last_word;
              state_nx  = PAD;
            end
          end else begin
            push_word = in;
          end
        end
      end
      PAD: begin
        if (!buffer_full) begin
          push = 1'b1;
          if (count == LAST_SLOT) begin
            push_word = 32'h0000_0080;
            state_nx  = DONE;
          end
        end
      end
      default: begin
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ACCEPT;
    end else begin
      state <= state_nx;
    end
  end

  // Block shift register and fill count; an ack only rewinds the count, old data shifts out naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      out   <= '0;
      count <= 5'd0;
    end else begin
      if (buffer_full && f_ack) begin
        count <= 5'd0;
      end else if (push) begin
        count <= count + 5'd1;
      end
      if (push) begin
        out <= {out[BLOCK_W-33:0], push_word};
      end
    end
  end

endmodule

// File: tb/tb_keccak_padder.sv
// tb/tb_keccak_padder.sv - randomized scoreboard bench for keccak_padder
module tb_keccak_padder;

  logic         clk;
  logic         reset;
  logic [31:0]  din;
  logic         in_ready;
  logic         is_last;
  logic [1:0]   byte_num;
  logic         buffer_full;
  logic [575:0] out;
  logic         out_ready;
  logic         f_ack;

  int total = 0;
  int bad   = 0;

  logic [575:0] exp_q[$];
  logic         ack_auto  = 1'b0;
  logic         ack_force = 1'b0;

  keccak_padder dut (
    .clk         (clk),
    .reset       (reset),
    .in          (din),
    .in_ready    (in_ready),
    .is_last     (is_last),
    .byte_num    (byte_num),
    .buffer_full (buffer_full),
    .out         (out),
    .out_ready   (out_ready),
    .f_ack       (f_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [575:0] act, input logic [575:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, expv);
    end
  endtask

  // Reference: pad the byte string with 0x01, zero-fill to a 72-byte multiple, set 0x80 on the last byte.
  task automatic model_push(input logic [7:0] m[$]);
    logic [7:0]   p[$];
    logic [575:0] blk;
    p = m;
    p.push_back(8'h01);
    while (p.size() % 72 != 0) p.push_back(8'h00);
    p[p.size()-1] = p[p.size()-1] | 8'h80;
    for (int k = 0; k < p.size() / 72; k++) begin
      blk = '0;
      for (int i = 0; i < 72; i++) blk[575-8*i -: 8] = p[k*72+i];
      exp_q.push_back(blk);
    end
  endtask

  // Offer one word until the padder can take it; it is taken on the edge after a negedge with buffer_full=0.
  task automatic offer(input logic [31:0] w, input logic last, input logic [1:0] bn);
    int   guard;
    logic taken;
    guard = 0;
    if ($urandom_range(0, 3) == 0) begin
      in_ready = 1'b0;
      @(negedge clk);
    end
    forever begin
      din      = w;
      is_last  = last;
      byte_num = bn;
      in_ready = 1'b1;
      taken    = (buffer_full == 1'b0);
      @(negedge clk);
      if (taken) break;
      guard++;
      if (guard > 500) begin
        chk("offer_timeout", 1, 0);
        break;
      end
    end
    in_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_ready = 1'b1;
    din      = $urandom;
    is_last  = 1'b0;
    byte_num = 2'd0;
    repeat (2) @(negedge clk);
    reset    = 1'b0;
    in_ready = 1'b0;
  endtask

  task automatic run_msg(input int len);
    logic [7:0]   m[$];
    logic [31:0]  w;
    logic [575:0] saved;
    int           guard;
    m = {};
    do_reset();
    ack_auto = 1'b1;
    for (int i = 0; i < len; i++) m.push_back(8'($urandom));
    model_push(m);
    for (int i = 0; i < len / 4; i++) begin
      w = {m[4*i], m[4*i+1], m[4*i+2], m[4*i+3]};
      offer(w, 1'b0, 2'($urandom));
    end
    w = $urandom;
    for (int j = 0; j < len % 4; j++) w[31-8*j -: 8] = m[4*(len/4)+j];
    offer(w, 1'b1, 2'(len % 4));
    guard = 0;
    while (exp_q.size() != 0 || out_ready !== 1'b0) begin
      @(negedge clk);
      guard++;
      if (guard > 3000) begin
        chk("drain_timeout", 1, 0);
        exp_q = {};
        break;
      end
    end
    // Message finished: host words must be ignored until reset.
    saved = out;
    for (int i = 0; i < 6; i++) begin
      din      = $urandom;
      is_last  = 1'($urandom);
      in_ready = 1'b1;
      @(negedge clk);
    end
    in_ready = 1'b0;
    chk("done_out_stable", out, saved);
    chk("done_not_full", buffer_full, 0);
  endtask

  // Ack driver: random acks (including stray ones while not full) or a directed level.
  initial begin
    f_ack = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      f_ack = ack_auto ? ($urandom_range(0, 3) == 0) : ack_force;
    end
  end

  // Monitor: each newly presented block is compared against the scoreboard; it must hold until acked.
  initial begin
    logic         prev;
    logic [575:0] held;
    prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b0) begin
        prev = 1'b0;
      end else begin
        chk("rdy_eq_full", out_ready, buffer_full);
        if (out_ready === 1'b1 && !prev) begin
          if (exp_q.size() == 0) chk("unexpected_block", 1, 0);
          else chk("block", out, exp_q.pop_front());
          held = out;
        end else if (out_ready === 1'b1) begin
          chk("block_hold", out, held);
        end
        prev = (out_ready === 1'b1);
      end
    end
  end

  initial begin
    logic [7:0] m[$];
    reset    = 1'b1;
    in_ready = 1'b0;
    din      = 32'h0;
    is_last  = 1'b0;
    byte_num = 2'd0;

    // Reset with in_ready high.
    do_reset();
    chk("reset_out", out, 0);
    chk("reset_full", buffer_full, 0);
    chk("reset_ready", out_ready, 0);

    // Eighteen plain words, held block, then the first word of the next block.
    ack_auto  = 1'b0;
    ack_force = 1'b0;
    m = {};
    for (int i = 0; i < 18; i++) begin
      m.push_back(8'h00); m.push_back(8'h00); m.push_back(8'h00); m.push_back(8'(i));
    end
    begin
      logic [575:0] blk;
      for (int i = 0; i < 72; i++) blk[575-8*i -: 8] = m[i];
      exp_q.push_back(blk);
    end
    for (int i = 0; i < 18; i++) offer(32'(i), 1'b0, 2'd0);
    chk("full_after_18", buffer_full, 1);
    chk("first_word_pos", out[575:544], 32'h0);
    chk("last_word_pos", out[31:0], 32'h11);
    din      = 32'hDEAD_BEEF;
    in_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("hold_last_word", out[31:0], 32'h11);
    chk("hold_full", buffer_full, 1);
    ack_force = 1'b1;
    in_ready  = 1'b0;
    @(negedge clk);
    ack_force = 1'b0;
    chk("ack_clears_full", buffer_full, 0);
    offer(32'h0000_0055, 1'b0, 2'd0);
    chk("next_word_lands", out[31:0], 32'h55);
    chk("prev_word_shifted", out[63:32], 32'h11);

    // Reset in the middle of padding discards the partial block.
    do_reset();
    ack_auto = 1'b1;
    offer(32'h1234_5678, 1'b1, 2'd1);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midpad_reset_out", out, 0);
    chk("midpad_reset_full", buffer_full, 0);
    offer(32'hCAFE_BABE, 1'b0, 2'd0);
    chk("after_reset_word", out[31:0], 32'hCAFE_BABE);
    chk("after_reset_prev", out[63:32], 32'h0);

    // Boundary lengths: empty, two bytes, 71 bytes (0x81 tail), 72 bytes (second block), then random.
    run_msg(0);
    run_msg(2);
    run_msg(71);
    run_msg(72);
    run_msg(143);
    for (int i = 0; i < 10; i++) run_msg($urandom_range(0, 200));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
